// File: rtl/fp_norm_pkg.sv
// Purpose: shared widths, request/stage structs and small helpers for the FP normalization stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   MANT_W / EXP_W / LZC_W  default datapath widths (mantissa incl. hidden bit, biased exponent, LZC)
//   norm_req_t              upstream request as seen by S1
//   norm_s1_t               S1 -> S2 stage register contents (decision already made, shift pending)
//   norm_lead_bit_set()     true when the bit i_lzc positions below the MSB is a one
package fp_norm_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int LZC_W  = 5;

    // Upstream request, minus the leading-zero count which only steers the S1 decision.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              zero;
    } norm_req_t;

    // S1 result: everything S2 needs to produce the final outputs with one shift.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              uf;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [LZC_W-1:0]  sh;
    } norm_s1_t;

    // A one-hot mask walked down from the MSB by lzc. Any lzc >= MANT_W shifts the
    // mask out entirely, so an out-of-range count also reports "no leading one".
    function automatic logic norm_lead_bit_set(
        input logic [MANT_W-1:0] mant,
        input logic [LZC_W-1:0]  lzc
    );
        logic [MANT_W-1:0] mask;
        mask = {1'b1, {(MANT_W-1){1'b0}}} >> lzc;
        return |(mant & mask);
    endfunction

endpackage

// File: rtl/fp_norm_barrel_shl.sv
// Purpose: logarithmic left barrel shifter, zero-fill on the right, bits shifted off the top are lost.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; data in, data out.
//
// Ports:
//   i_dat  in   MANT_W  data to shift
//   i_sh   in   LZC_W   left shift amount
//   o_dat  out  MANT_W  shifted data
module fp_norm_barrel_shl
    import fp_norm_pkg::*;
#(
    parameter int DW = MANT_W,
    parameter int SW = LZC_W
) (
    input  logic [DW-1:0] i_dat,
    input  logic [SW-1:0] i_sh,
    output logic [DW-1:0] o_dat
);

    // w_stage[k] holds the data after the shift bits below k have been applied.
    logic [DW-1:0] w_stage [0:SW];

    assign w_stage[0] = i_dat;

    genvar k;
    generate
        for (k = 0; k < SW; k++) begin : g_stage
            assign w_stage[k+1] = i_sh[k] ? (w_stage[k] << (2**k)) : w_stage[k];
        end
    endgenerate

    assign o_dat = w_stage[SW];

endmodule

// File: rtl/fp_norm_shift.sv
// Purpose: FP add/sub normalization stage; shifts the hidden bit to the MSB and adjusts the exponent.
// Latency: 2 cycles input transfer -> o_valid (S1 decide, S2 shift), 1 result per cycle.
// Backpressure: elastic valid/ready; o_ready depends on i_ready and stage occupancy only, never i_valid.
//
// Build option: define FP_NORM_FTZ_EN to flush every underflow result to zero
// (o_mant=0, o_exp=0, o_zero=1, o_underflow=1, sign kept). Undefined: denormal results.
//
// Ports:
//   i_clk, i_rst           clock (rising edge) and synchronous active-high reset
//   i_valid / o_ready      upstream handshake
//   i_mant, i_exp, i_lzc   unnormalized mantissa, biased exponent, leading-zero count
//   i_zero, i_sign         LOPD zero flag, result sign
//   o_valid / i_ready      downstream handshake toward the rounding stage
//   o_mant, o_exp          normalized (or denormal) mantissa and adjusted exponent
//   o_sign, o_zero         sign and exact-zero flag delayed with the data
//   o_underflow            exponent could not absorb the full normalization shift
module fp_norm_shift
    import fp_norm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [LZC_W-1:0]  i_lzc,
    input  logic              i_zero,
    input  logic              i_sign,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [MANT_W-1:0] o_mant,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_sign,
    output logic              o_zero,
    output logic              o_underflow
);

    // ------------------------------------------------------------------
    // Request packing and S1 decision
    // ------------------------------------------------------------------
    norm_req_t        w_req;
    norm_s1_t         w_s1_nxt;
    logic [EXP_W-1:0] w_lzc_ext;
    logic [LZC_W-1:0] w_sh_uf;

    assign w_req     = '{sign: i_sign, exp: i_exp, mant: i_mant, zero: i_zero};
    assign w_lzc_ext = {{(EXP_W-LZC_W){1'b0}}, i_lzc};

    // On the underflow path i_exp <= i_lzc < MANT_W, so i_exp-1 always fits in LZC_W bits.
    // Shifting by exp-1 leaves the value at the minimum normal exponent scaled as a denormal.
    assign w_sh_uf = (w_req.exp == '0) ? '0 : LZC_W'(w_req.exp - EXP_W'(1));

    always_comb begin
        w_s1_nxt      = '0;
        w_s1_nxt.sign = w_req.sign;
        w_s1_nxt.mant = w_req.mant;
        if (w_req.zero) begin
            w_s1_nxt.zero = 1'b1;
            w_s1_nxt.sh   = '0;
            w_s1_nxt.exp  = '0;
            w_s1_nxt.uf   = 1'b0;
        end else if (w_req.exp > w_lzc_ext) begin
            // Exponent stays >= 1 after the full shift: normal result.
            w_s1_nxt.sh   = i_lzc;
            w_s1_nxt.exp  = w_req.exp - w_lzc_ext;
            w_s1_nxt.uf   = 1'b0;
        end else begin
            // Exponent would reach zero or below: partial shift, denormal result.
            w_s1_nxt.sh   = w_sh_uf;
            w_s1_nxt.exp  = '0;
            w_s1_nxt.uf   = 1'b1;
`ifdef FP_NORM_FTZ_EN
            w_s1_nxt.mant = '0;
            w_s1_nxt.zero = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Elastic control
    // ------------------------------------------------------------------
    logic w_s2_ld;
    logic w_s1_adv;
    logic w_s1_ld;
    logic r_s1_v;
    logic r_s2_v;

    // S2 can take new data when empty or when its current result leaves this cycle.
    assign w_s2_ld  = ~r_s2_v | i_ready;
    assign w_s1_adv = r_s1_v & w_s2_ld;
    assign w_s1_ld  = ~r_s1_v | w_s1_adv;
    assign o_ready  = w_s1_ld;

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    norm_s1_t r_s1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_s1_ld) begin
            r_s1_v <= i_valid;
            if (i_valid) begin
                r_s1 <= w_s1_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: shift and output registers
    // ------------------------------------------------------------------
    logic [MANT_W-1:0] w_shl_mant;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_sign;
    logic              r_zero;
    logic              r_uf;

    fp_norm_barrel_shl #(
        .DW (MANT_W),
        .SW (LZC_W)
    ) u_shl (
        .i_dat (r_s1.mant),
        .i_sh  (r_s1.sh),
        .o_dat (w_shl_mant)
    );

    // Data registers only load on a real advance, so a stalled result stays
    // bit-for-bit stable and a bubble does not disturb the last delivered value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_v <= 1'b0;
            r_mant <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_zero <= 1'b0;
            r_uf   <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_mant <= w_shl_mant;
                r_exp  <= r_s1.exp;
                r_sign <= r_s1.sign;
                r_zero <= r_s1.zero;
                r_uf   <= r_s1.uf;
            end
        end
    end

    assign o_valid     = r_s2_v;
    assign o_mant      = r_mant;
    assign o_exp       = r_exp;
    assign o_sign      = r_sign;
    assign o_zero      = r_zero;
    assign o_underflow = r_uf;

    // ------------------------------------------------------------------
    // Input legality: a non-zero mantissa must have a one exactly i_lzc
    // places below the MSB, otherwise the shift would not normalize it.
    // ------------------------------------------------------------------
    logic w_illegal;

    assign w_illegal = i_valid & ~i_zero & ~norm_lead_bit_set(i_mant, i_lzc);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            a_lzc_legal: assert (!w_illegal);
        end
    end

endmodule

// File: tb/tb_fp_norm_shift.sv
// Purpose: directed self-checking bench for fp_norm_shift.
// Latency: checks the 2-cycle input-to-output latency and streaming throughput.
// Backpressure: exercises i_ready stalls, o_ready deassertion and reset with data in flight.
module tb_fp_norm_shift;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_mant;
    logic [7:0]  i_exp;
    logic [4:0]  i_lzc;
    logic        i_zero;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_mant;
    logic [7:0]  o_exp;
    logic        o_sign;
    logic        o_zero;
    logic        o_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    fp_norm_shift dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mant      (i_mant),
        .i_exp       (i_exp),
        .i_lzc       (i_lzc),
        .i_zero      (i_zero),
        .i_sign      (i_sign),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_mant      (o_mant),
        .o_exp       (o_exp),
        .o_sign      (o_sign),
        .o_zero      (o_zero),
        .o_underflow (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with i_ready=1. Input transfers at the next posedge,
    // result must be absent one negedge later and present the negedge after that.
    task automatic run_one(input string tag,
                           input logic [23:0] m, input logic [7:0] e, input logic [4:0] l,
                           input logic z, input logic s,
                           input logic [23:0] xm, input logic [7:0] xe,
                           input logic xz, input logic xu);
        i_valid = 1'b1;
        i_mant  = m;
        i_exp   = e;
        i_lzc   = l;
        i_zero  = z;
        i_sign  = s;
        #1;
        chk({tag, "_in_rdy"}, 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk({tag, "_lat_early"}, 64'(o_valid), 64'd0);
        @(negedge i_clk);
        chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_mant"},  64'(o_mant), 64'(xm));
        chk({tag, "_exp"},   64'(o_exp),  64'(xe));
        chk({tag, "_flags"}, 64'({o_sign, o_zero, o_underflow}), 64'({s, xz, xu}));
        @(negedge i_clk);
        chk({tag, "_drained"}, 64'(o_valid), 64'd0);
    endtask

    logic [32:0] exp_q[$];
    logic [32:0] snap;
    logic [32:0] head;
    logic        snap_v;
    int          sent;
    int          got;
    int          n_fl;

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_mant  = '0;
        i_exp   = '0;
        i_lzc   = '0;
        i_zero  = 1'b0;
        i_sign  = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);

        // Reset state
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data",  64'({o_mant, o_exp, o_sign, o_zero, o_underflow}), 64'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);

        // Normal shift: 0x000F00 << 12, exponent 100-12
        run_one("t1", 24'h000F00, 8'd100, 5'd12, 1'b0, 1'b0, 24'hF00000, 8'd88, 1'b0, 1'b0);
        // Exact zero
        run_one("t2", 24'h000000, 8'd50, 5'd0, 1'b1, 1'b1, 24'h000000, 8'd0, 1'b1, 1'b0);
        // Already normal, no shift
        run_one("t_nosh", 24'h812345, 8'd1, 5'd0, 1'b0, 1'b1, 24'h812345, 8'd1, 1'b0, 1'b0);
`ifdef FP_NORM_FTZ_EN
        run_one("t3", 24'h000100, 8'd5, 5'd15, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b1, 1'b1);
        run_one("t6", 24'h1FFFFF, 8'd3, 5'd3, 1'b0, 1'b1, 24'h000000, 8'd0, 1'b1, 1'b1);
        run_one("t_e0", 24'h000003, 8'd0, 5'd22, 1'b0, 1'b0, 24'h000000, 8'd0, 1'b1, 1'b1);
`else
        // Underflow: shift limited to exp-1 = 4
        run_one("t3", 24'h000100, 8'd5, 5'd15, 1'b0, 1'b0, 24'h001000, 8'd0, 1'b0, 1'b1);
        // exp == lzc takes the underflow path, shift 2
        run_one("t6", 24'h1FFFFF, 8'd3, 5'd3, 1'b0, 1'b1, 24'h7FFFFC, 8'd0, 1'b0, 1'b1);
        // exp == 0: no shift at all
        run_one("t_e0", 24'h000003, 8'd0, 5'd22, 1'b0, 1'b0, 24'h000003, 8'd0, 1'b0, 1'b1);
`endif
        // exp just above lzc: normal, lands on exponent 1
        run_one("t_e1", 24'h000001, 8'd24, 5'd23, 1'b0, 1'b0, 24'h800000, 8'd1, 1'b0, 1'b0);

        // Streaming: 8 back-to-back inputs, i_ready pattern 1,0,0,1 repeating.
        // Item k: mant C00000>>k, lzc k, exp 50+3k -> mant C00000, exp 50+2k, sign k[0].
        sent   = 0;
        got    = 0;
        n_fl   = 0;
        snap_v = 1'b0;
        snap   = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (sent < 8) begin
                i_valid = 1'b1;
                i_mant  = 24'hC00000 >> sent;
                i_lzc   = 5'(sent);
                i_exp   = 8'(50 + 3 * sent);
                i_sign  = sent[0];
                i_zero  = 1'b0;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            chk("s_ordy", 64'(o_ready), 64'(!(n_fl == 2 && !i_ready)));
            if (snap_v) begin
                chk("s_hold_v", 64'(o_valid), 64'd1);
                chk("s_hold_d", 64'({o_sign, o_exp, o_mant}), 64'(snap));
            end
            snap_v = o_valid && !i_ready;
            snap   = {o_sign, o_exp, o_mant};
            if (o_valid && i_ready) begin
                chk("s_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    chk("s_data", 64'({o_sign, o_exp, o_mant}), 64'(head));
                    chk("s_flags", 64'({o_zero, o_underflow}), 64'd0);
                end
                got++;
                n_fl--;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back({sent[0], 8'(50 + 2 * sent), 24'hC00000});
                sent++;
                n_fl++;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("s_count", 64'(got), 64'd8);
        chk("s_q_empty", 64'(exp_q.size()), 64'd0);
        @(negedge i_clk);
        chk("s_no_extra", 64'(o_valid), 64'd0);

        // Reset with two requests in flight
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_mant  = 24'h400000;
        i_exp   = 8'd77;
        i_lzc   = 5'd1;
        i_sign  = 1'b1;
        i_zero  = 1'b0;
        @(negedge i_clk);
        i_mant  = 24'h020000;
        i_lzc   = 5'd6;
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("r_pre_valid", 64'(o_valid), 64'd1);
        chk("r_pre_ordy", 64'(o_ready), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("r_valid", 64'(o_valid), 64'd0);
        chk("r_data", 64'({o_mant, o_exp, o_sign, o_zero, o_underflow}), 64'd0);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("r_no_stale", 64'(o_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
